// File: rtl/garduino_sysinfo.sv
// garduino_sysinfo: Avalon-MM system-identification and housekeeping slave.
// Holds an 8-word map with build ID, timestamp, version, scratch, uptime
// seconds and a 64-bit cycle counter whose high word is snapshotted on reads
// of the low word. Reads return after a fixed, pipelined latency.
module garduino_sysinfo #(
    parameter logic [31:0] SYS_ID       = 32'h5F5C_2A60,
    parameter logic [31:0] TIMESTAMP    = 32'd1599928672,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter int unsigned CLK_FREQ_HZ  = 50000000,
    parameter int unsigned READ_LATENCY = 1,
    // Reset-time preload of UPTIME and the cycle counter; leave at 0 in the
    // system. Nonzero values let wrap behaviour be exercised in short runs.
    parameter logic [31:0] UPTIME_RST   = 32'h0,
    parameter logic [63:0] CYCLE_RST    = 64'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 64;
    localparam int unsigned BEW = 4;
    localparam int unsigned PDW = READ_LATENCY * DW;

    localparam logic [DW-1:0] PRESC_TERM = DW'(CLK_FREQ_HZ - 1);

    localparam logic [2:0] A_SYS_ID  = 3'd0;
    localparam logic [2:0] A_TSTAMP  = 3'd1;
    localparam logic [2:0] A_VERSION = 3'd2;
    localparam logic [2:0] A_SCRATCH = 3'd3;
    localparam logic [2:0] A_UPTIME  = 3'd4;
    localparam logic [2:0] A_CYC_LO  = 3'd5;
    localparam logic [2:0] A_CYC_HI  = 3'd6;
    localparam logic [2:0] A_CTRL    = 3'd7;

    logic [DW-1:0]           scratch_q, scratch_d;
    logic [DW-1:0]           presc_q, presc_d;
    logic [DW-1:0]           uptime_q, uptime_d;
    logic [CW-1:0]           cyc_q, cyc_d;
    logic [DW-1:0]           snap_q, snap_d;
    logic [PDW-1:0]          pipe_data_q, pipe_data_d;
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;

    logic          rd_acc_c;
    logic          clr_c;
    logic          tick_c;
    logic [DW-1:0] rdata_c;

    // A simultaneous write wins over the read, so the read is not accepted.
    assign rd_acc_c = read & ~write;
    assign clr_c    = write & (address == A_CTRL) & writedata[0];
    assign tick_c   = (presc_q == PRESC_TERM);

    // Read mux: register values as they stand before this cycle's updates.
    always_comb begin
        rdata_c = '0;
        case (address)
            A_SYS_ID:  rdata_c = SYS_ID;
            A_TSTAMP:  rdata_c = TIMESTAMP;
            A_VERSION: rdata_c = VERSION;
            A_SCRATCH: rdata_c = scratch_q;
            A_UPTIME:  rdata_c = uptime_q;
            A_CYC_LO:  rdata_c = cyc_q[DW-1:0];
            A_CYC_HI:  rdata_c = snap_q;
            A_CTRL:    rdata_c = '0;
            default:   rdata_c = '0;
        endcase
    end

    // Next state of prescaler, uptime and cycle counter; clear has priority.
    always_comb begin
        presc_d  = presc_q + DW'(1);
        uptime_d = uptime_q;
        cyc_d    = cyc_q + CW'(1);
        if (tick_c) begin
            presc_d  = '0;
            uptime_d = uptime_q + DW'(1);
        end
        if (clr_c) begin
            presc_d  = '0;
            uptime_d = '0;
            cyc_d    = '0;
        end
    end

    // Next state of scratch (byte-enabled) and the high-word snapshot.
    always_comb begin
        scratch_d = scratch_q;
        snap_d    = snap_q;
        if (write && (address == A_SCRATCH)) begin
            for (int unsigned i = 0; i < BEW; i++) begin
                if (byteenable[i]) begin
                    scratch_d[8*i +: 8] = writedata[8*i +: 8];
                end
            end
        end
        if (rd_acc_c && (address == A_CYC_LO)) begin
            snap_d = cyc_q[CW-1:DW];
        end
    end

    // Read pipeline shift; data is forced to 0 in stages that hold no read.
    always_comb begin
        pipe_vld_d  = (pipe_vld_q << 1) | READ_LATENCY'(rd_acc_c);
        pipe_data_d = (pipe_data_q << DW) | PDW'(rd_acc_c ? rdata_c : '0);
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q   <= '0;
            presc_q     <= '0;
            uptime_q    <= UPTIME_RST;
            cyc_q       <= CYCLE_RST;
            snap_q      <= '0;
            pipe_data_q <= '0;
            pipe_vld_q  <= '0;
        end else begin
            scratch_q   <= scratch_d;
            presc_q     <= presc_d;
            uptime_q    <= uptime_d;
            cyc_q       <= cyc_d;
            snap_q      <= snap_d;
            pipe_data_q <= pipe_data_d;
            pipe_vld_q  <= pipe_vld_d;
        end
    end

    assign readdata      = pipe_data_q[PDW-1 -: DW];
    assign readdatavalid = pipe_vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_garduino_sysinfo.sv
// Bench for garduino_sysinfo: two instances (uptime/latency instance and a
// preloaded wrap/snapshot instance) checked every cycle against a model.
module tb_garduino_sysinfo;

    localparam int unsigned FREQ_A = 10;
    localparam int unsigned RL_A   = 2;
    localparam int unsigned FREQ_B = 2;
    localparam logic [31:0] UP_B   = 32'hFFFF_FFFF;
    localparam logic [63:0] CY_B   = 64'h0000_0000_FFFF_FFF0;
    localparam logic [31:0] ID_V   = 32'h5F5C_2A60;
    localparam logic [31:0] TS_V   = 32'd1599928672;
    localparam logic [31:0] VER_V  = 32'h0001_0000;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [2:0]  a_addr, b_addr;
    logic        a_read, a_write, b_read, b_write;
    logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic [3:0]  a_be, b_be;
    logic        a_rdv, b_rdv;

    // Model state: t/t2 are clock edges since the last reset or clear.
    logic [63:0] t, t2;
    logic [31:0] scr_m, snap_m, snap2_m;
    int unsigned cyc_no;
    exp_t        qa[$], qb[$];
    int          total, bad;

    garduino_sysinfo #(
        .CLK_FREQ_HZ (FREQ_A),
        .READ_LATENCY(RL_A)
    ) u_dut_a (
        .clock        (clock),
        .reset_n      (reset_n),
        .address      (a_addr),
        .read         (a_read),
        .write        (a_write),
        .writedata    (a_wdata),
        .byteenable   (a_be),
        .readdata     (a_rdata),
        .readdatavalid(a_rdv)
    );

    garduino_sysinfo #(
        .CLK_FREQ_HZ (FREQ_B),
        .READ_LATENCY(1),
        .UPTIME_RST  (UP_B),
        .CYCLE_RST   (CY_B)
    ) u_dut_b (
        .clock        (clock),
        .reset_n      (reset_n),
        .address      (b_addr),
        .read         (b_read),
        .write        (b_write),
        .writedata    (b_wdata),
        .byteenable   (b_be),
        .readdata     (b_rdata),
        .readdatavalid(b_rdv)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc_no, obs, exp);
        end
    endtask

    function automatic logic [31:0] a_val(input logic [2:0] ad);
        case (ad)
            3'd0:    return ID_V;
            3'd1:    return TS_V;
            3'd2:    return VER_V;
            3'd3:    return scr_m;
            3'd4:    return 32'(t / 64'(FREQ_A));
            3'd5:    return t[31:0];
            3'd6:    return snap_m;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] b_val(input logic [2:0] ad);
        logic [63:0] c;
        c = CY_B + t2;
        case (ad)
            3'd0:    return ID_V;
            3'd1:    return TS_V;
            3'd2:    return VER_V;
            3'd3:    return 32'h0;
            3'd4:    return UP_B + 32'(t2 / 64'(FREQ_B));
            3'd5:    return c[31:0];
            3'd6:    return snap2_m;
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle();
        a_read = 1'b0; a_write = 1'b0; a_addr = 3'd0; a_wdata = 32'h0; a_be = 4'h0;
        b_read = 1'b0; b_write = 1'b0; b_addr = 3'd0; b_wdata = 32'h0; b_be = 4'h0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_rdv"}, {31'b0, a_rdv}, 32'h0);
        chk({tag, "_a_rdata"}, a_rdata, 32'h0);
        chk({tag, "_b_rdv"}, {31'b0, b_rdv}, 32'h0);
        chk({tag, "_b_rdata"}, b_rdata, 32'h0);
    endtask

    // One clock: update the model with the presented request, advance, check.
    task automatic tick();
        logic        clr;
        exp_t        e;
        logic [63:0] c;
        logic        ev;
        logic [31:0] ed;
        clr = 1'b0;
        if (a_read && !a_write) begin
            e.due = cyc_no + RL_A; e.data = a_val(a_addr); qa.push_back(e);
            if (a_addr == 3'd5) snap_m = t[63:32];
        end
        if (a_write) begin
            if (a_addr == 3'd3)
                for (int i = 0; i < 4; i++) if (a_be[i]) scr_m[8*i +: 8] = a_wdata[8*i +: 8];
            if (a_addr == 3'd7 && a_wdata[0]) clr = 1'b1;
        end
        if (b_read && !b_write) begin
            e.due = cyc_no + 1; e.data = b_val(b_addr); qb.push_back(e);
            c = CY_B + t2;
            if (b_addr == 3'd5) snap2_m = c[63:32];
        end
        @(posedge clock);
        #1;
        cyc_no++;
        t  = clr ? 64'h0 : t + 64'h1;
        t2 = t2 + 64'h1;
        ev = 1'b0; ed = 32'h0;
        if (qa.size() > 0 && qa[0].due == cyc_no) begin
            ev = 1'b1; ed = qa[0].data; void'(qa.pop_front());
        end
        chk("a_rdv", {31'b0, a_rdv}, {31'b0, ev});
        chk("a_rdata", a_rdata, ed);
        ev = 1'b0; ed = 32'h0;
        if (qb.size() > 0 && qb[0].due == cyc_no) begin
            ev = 1'b1; ed = qb[0].data; void'(qb.pop_front());
        end
        chk("b_rdv", {31'b0, b_rdv}, {31'b0, ev});
        chk("b_rdata", b_rdata, ed);
        idle();
    endtask

    task automatic model_reset();
        t = 64'h0; t2 = 64'h0; scr_m = 32'h0; snap_m = 32'h0; snap2_m = 32'h0;
        qa.delete(); qb.delete();
    endtask

    initial begin
        total = 0; bad = 0; cyc_no = 0;
        idle();
        model_reset();
        reset_n = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            chk_zero("reset");
        end
        reset_n = 1'b1;

        // ID words back to back; B reads preloaded uptime, then after wrap
        a_read = 1'b1; a_addr = 3'd0; b_read = 1'b1; b_addr = 3'd4; tick();
        a_read = 1'b1; a_addr = 3'd1; tick();
        a_read = 1'b1; a_addr = 3'd2; b_read = 1'b1; b_addr = 3'd4; tick();
        tick(); tick();

        // Scratch byte enables and RO write ignored
        a_write = 1'b1; a_addr = 3'd3; a_wdata = 32'hAABB_CCDD; a_be = 4'hF; tick();
        a_write = 1'b1; a_addr = 3'd3; a_wdata = 32'h1122_3344; a_be = 4'h5; tick();
        a_read = 1'b1; a_addr = 3'd3; tick();
        a_write = 1'b1; a_addr = 3'd0; a_wdata = 32'hDEAD_BEEF; a_be = 4'hF; tick();
        a_read = 1'b1; a_addr = 3'd0; tick();
        tick(); tick();

        // Snapshot coherency across the carry into the high word
        for (int k = 0; k < 40 && t2 < 64'd15; k++) tick();
        b_read = 1'b1; b_addr = 3'd5; tick();
        tick(); tick();
        b_read = 1'b1; b_addr = 3'd6; tick();
        b_read = 1'b1; b_addr = 3'd5; tick();
        b_read = 1'b1; b_addr = 3'd6; tick();
        tick();

        // Uptime count and clear colliding with a tick
        for (int k = 0; k < 60 && t < 64'd35; k++) tick();
        a_read = 1'b1; a_addr = 3'd4; tick();
        for (int k = 0; k < 20 && (t % 64'(FREQ_A)) != 64'(FREQ_A - 1); k++) tick();
        a_write = 1'b1; a_addr = 3'd7; a_wdata = 32'h1; a_be = 4'hF; tick();
        a_read = 1'b1; a_addr = 3'd4; tick();
        a_read = 1'b1; a_addr = 3'd5; tick();
        a_read = 1'b1; a_addr = 3'd6; tick();
        tick(); tick();

        // Read+write collision: write lands, read dropped
        a_read = 1'b1; a_write = 1'b1; a_addr = 3'd3; a_wdata = 32'h1234_5678; a_be = 4'hF; tick();
        a_read = 1'b1; a_addr = 3'd3; tick();
        tick(); tick();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            a_addr  = 3'($urandom_range(0, 7));
            a_read  = ($urandom_range(0, 3) != 0);
            a_write = ($urandom_range(0, 4) == 0);
            a_wdata = $urandom;
            a_be    = 4'($urandom_range(0, 15));
            if (a_write && a_addr == 3'd7) a_wdata[0] = ($urandom_range(0, 3) == 0);
            b_read  = ($urandom_range(0, 1) == 1);
            b_addr  = 3'($urandom_range(0, 7));
            tick();
        end
        tick(); tick(); tick();

        // Reset with reads in flight
        a_read = 1'b1; a_addr = 3'd0; b_read = 1'b1; b_addr = 3'd0; tick();
        a_read = 1'b1; a_addr = 3'd1; tick();
        reset_n = 1'b0;
        #1;
        chk_zero("rst_async");
        model_reset();
        repeat (2) begin
            @(posedge clock);
            #1;
            chk_zero("rst_hold");
        end
        reset_n = 1'b1;
        repeat (4) tick();
        a_read = 1'b1; a_addr = 3'd3; b_read = 1'b1; b_addr = 3'd4; tick();
        a_read = 1'b1; a_addr = 3'd5; b_read = 1'b1; b_addr = 3'd5; tick();
        a_read = 1'b1; a_addr = 3'd6; b_read = 1'b1; b_addr = 3'd6; tick();
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
